image_pipe_arb: RTL and testbench
=================================

Name: image_pipe_arb

Overview:
Frame-level round-robin arbiter that shares one image_pipe input port between NUM_SRC upstream image sources. It grants one source for a whole frame, from its first valid beat until its end strobe, and muxes that source's data/valid/end onto the pipe. It routes the pipe's busy back to the granted source and holds all other sources busy. It also reports per-frame beat counts and aborts a frame that stalls.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DW, 32, pixel data width, equal to image_pipe DW_IN
TIMEOUT, 1024, idle cycles inside a granted frame before abort (≥2)
CNT_W, 16, width of beat counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
src_data_in  input  NUM_SRC*DW  source data, source i at [i*DW +: DW]
src_valid_in  input  NUM_SRC  source beat valid
src_end_in  input  NUM_SRC  source end-of-frame strobe
src_busy_out  output  NUM_SRC  per-source backpressure
pipe_data_out  output  DW  to image_pipe is_data_in
pipe_valid_out  output  1  to image_pipe is_valid_in
pipe_end_out  output  1  to image_pipe is_end_in
pipe_busy_in  input  1  from image_pipe is_busy_out
grant_out  output  NUM_SRC  one-hot current grant, 0 when idle
frame_beats_out  output  CNT_W  beats in last completed frame
frame_done_out  output  1  1-cycle pulse; frame_beats_out updated
timeout_out  output  1  1-cycle pulse on frame abort

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- Beat transfer: in a cycle where pipe_valid_out=1 and pipe_busy_in=0.
- FSM states: IDLE, XFER, CLOSE.
- IDLE:
  - Requesters are src_valid_in[i].
  - Pick the first requester at or after rr_ptr, wrapping modulo NUM_SRC.
  - Register the one-hot grant and go to XFER.
  - No requester: stay IDLE.
  - A src_end_in with no grant is ignored.
- Grant latency: the winner is selected in cycle t; grant_out is valid from t+1. The winner's beat offered in cycle t is not consumed, because its src_busy_out is 1 in IDLE.
- XFER datapath (combinational, 0 latency):
  - pipe_data_out, pipe_valid_out and pipe_end_out are the granted source's signals.
  - src_busy_out[g] = pipe_busy_in; every other bit = 1.
- Outside XFER:
  - pipe_data_out = 0, pipe_valid_out = 0, pipe_end_out = 0.
  - src_busy_out = all ones.
- End of frame in XFER:
  - src_end_in[g]=1 goes to CLOSE next cycle.
  - A valid beat in the same cycle as end transfers normally and is counted.
- CLOSE (one cycle):
  - frame_done_out=1; frame_beats_out = final count.
  - rr_ptr = (g+1) mod NUM_SRC; grant cleared; next state IDLE.
- Beat counter:
  - Cleared on entry to XFER; increments per transferred beat.
  - Saturates at 2^CNT_W-1, no wrap.
- Watchdog:
  - idle_cnt counts XFER cycles with no transferred beat and no end; reset by any beat.
  - Cycles with pipe_busy_in=1 also count.
  - When idle_cnt reaches TIMEOUT-1: drive pipe_end_out=1 for that cycle (synthetic end), pulse timeout_out, go to CLOSE.
  - CLOSE then reports the partial count with frame_done_out.
- Reset values:
  - State IDLE, rr_ptr 0, grant_out 0, counters 0.
  - frame_beats_out 0, frame_done_out 0, timeout_out 0, src_busy_out all ones.
- Reset mid-frame: immediate return to IDLE next edge; no end is emitted. The downstream pipe is reset by the same system reset.
- Only the granted source is ever unbusy, so sources never interleave.

Decomposition:
- Package image_pipe_pkg:
  - arb_state_e enum {IDLE, XFER, CLOSE}.
  - Default DW and CNT_W localparams.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module rr_arbiter: combinational pick from req/ptr, parameterised on NUM_SRC.
- FSM, counters and mux stay in image_pipe_arb.

Test Plan:
- Single source: src1 sends 8 beats then end, pipe_busy_in=0 → grant_out=4'b0010 one cycle after first valid; 8 beats on pipe; frame_done_out with frame_beats_out=8; rr_ptr=2.
- Contention: src0 and src2 valid together from reset → src0 frame first. Then src2; src0 re-requesting after its end loses to src2. Grants 0001 then 0100.
- Backpressure: src3 frame of 5 beats; pipe_busy_in high for 3 cycles mid-frame → src_busy_out[3]=1 for those cycles; other bits always 1; frame_beats_out=5, no duplicate beats.
- Valid+end same cycle: final beat with end → counted; pipe_end_out=1 that cycle; CLOSE next cycle.
- Timeout: TIMEOUT=16; src0 sends 3 beats then stalls → timeout_out and pipe_end_out pulse 16 XFER cycles after last beat (idle_cnt=15); frame_beats_out=3; returns to IDLE.
- Reset mid-frame: rst during src2 frame after 4 beats → next cycle grant_out=0, src_busy_out=all ones, no frame_done_out; next frame is arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/image_pipe_arb_pkg.sv
// image_pipe_pkg: shared types, defaults and round-robin pick helper for image_pipe_arb
//   arb_state_e : frame arbiter states
//   rr_pick     : one-hot grant of the first requester at or after ptr, modulo n
package image_pipe_pkg;

    typedef enum logic [1:0] {IDLE, XFER, CLOSE} arb_state_e;

    localparam int DEF_DW    = 32;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_SRC   = 8;

    // Scans from the farthest slot down so the nearest requester overwrites last and wins.
    function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req, input int ptr, input int n);
        logic [2:0] idx;
        rr_pick = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = 3'((ptr + k) % n);
                if (req[idx]) rr_pick = MAX_SRC'(1) << idx;
            end
        end
    endfunction

endpackage

// File: rtl/image_pipe_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick
//   req : per-source request
//   ptr : highest-priority source index
//   gnt : one-hot winner, 0 when no request
module rr_arbiter import image_pipe_pkg::*; #(
    parameter int NUM_SRC = 4,
    parameter int PW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt
);

    logic [MAX_SRC-1:0] pick;
    logic               unused_pick;

    always_comb begin
        pick = rr_pick(MAX_SRC'(req), int'(ptr), NUM_SRC);
        gnt  = pick[NUM_SRC-1:0];
    end

    // Slots above NUM_SRC are never selected.
    assign unused_pick = ^pick;

endmodule

// File: rtl/image_pipe_arb.sv
// image_pipe_arb: frame-level round-robin arbiter sharing one image_pipe input
//   src_*_in / src_busy_out : NUM_SRC upstream sources, data packed at [i*DW +: DW]
//   pipe_*_out / pipe_busy_in : single downstream image_pipe port
//   grant_out : one-hot current owner; frame_beats_out/frame_done_out : per-frame report
//   timeout_out : pulse when a stalled frame is aborted with a synthetic end
module image_pipe_arb import image_pipe_pkg::*; #(
    parameter int NUM_SRC = 4,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*DW-1:0] src_data_in,
    input  logic [NUM_SRC-1:0]    src_valid_in,
    input  logic [NUM_SRC-1:0]    src_end_in,
    output logic [NUM_SRC-1:0]    src_busy_out,
    output logic [DW-1:0]         pipe_data_out,
    output logic                  pipe_valid_out,
    output logic                  pipe_end_out,
    input  logic                  pipe_busy_in,
    output logic [NUM_SRC-1:0]    grant_out,
    output logic [CNT_W-1:0]      frame_beats_out,
    output logic                  frame_done_out,
    output logic                  timeout_out
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int TW = $clog2(TIMEOUT);

    arb_state_e         state, state_n;
    logic [NUM_SRC-1:0] grant, pick;
    logic [PW-1:0]      rr_ptr, gidx;
    logic [CNT_W-1:0]   beat_cnt, cnt_n;
    logic [TW-1:0]      idle_cnt;
    logic               xfer, vin, ein, beat;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req (src_valid_in),
        .ptr (rr_ptr),
        .gnt (pick)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (grant[i]) gidx = PW'(i);
    end

    always_comb begin
        xfer           = state == XFER;
        vin            = src_valid_in[gidx];
        ein            = src_end_in[gidx];
        pipe_data_out  = xfer ? src_data_in[gidx*DW +: DW] : '0;
        pipe_valid_out = xfer & vin;
        beat           = pipe_valid_out & ~pipe_busy_in;
        // Abort only on a cycle that would itself have extended the stall.
        timeout_out    = xfer & ~beat & ~ein & (idle_cnt == TW'(TIMEOUT - 1));
        pipe_end_out   = xfer & (ein | timeout_out);
        src_busy_out   = xfer ? (~grant | {NUM_SRC{pipe_busy_in}}) : '1;
        frame_done_out = state == CLOSE;
        cnt_n          = (beat && beat_cnt != '1) ? beat_cnt + CNT_W'(1) : beat_cnt;
        state_n        = state == IDLE ? (|pick ? XFER : IDLE) :
                         state == XFER ? (pipe_end_out ? CLOSE : XFER) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            grant           <= '0;
            beat_cnt        <= '0;
            idle_cnt        <= '0;
            frame_beats_out <= '0;
        end else begin
            if (state == IDLE) begin
                grant    <= pick;
                beat_cnt <= '0;
                idle_cnt <= '0;
            end
            if (xfer) begin
                beat_cnt <= cnt_n;
                idle_cnt <= (beat | ein) ? '0 : idle_cnt + TW'(1);
                if (pipe_end_out) frame_beats_out <= cnt_n;
            end
            if (frame_done_out) begin
                grant  <= '0;
                rr_ptr <= (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + PW'(1);
            end
        end
    end

    assign grant_out = grant;

endmodule

// File: tb/tb_image_pipe_arb.sv
// tb_image_pipe_arb: directed bench with a frame-level reference model checked every cycle
module tb_image_pipe_arb;

    logic        clk = 0;
    logic        rst = 1;
    logic [127:0] src_data_in = '0;
    logic [3:0]  src_valid_in = '0;
    logic [3:0]  src_end_in = '0;
    logic [3:0]  src_busy_out;
    logic [31:0] pipe_data_out;
    logic        pipe_valid_out;
    logic        pipe_end_out;
    logic        pipe_busy_in = 0;
    logic [3:0]  grant_out;
    logic [15:0] frame_beats_out;
    logic        frame_done_out;
    logic        timeout_out;

    image_pipe_arb #(.NUM_SRC(4), .DW(32), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_data_in     (src_data_in),
        .src_valid_in    (src_valid_in),
        .src_end_in      (src_end_in),
        .src_busy_out    (src_busy_out),
        .pipe_data_out   (pipe_data_out),
        .pipe_valid_out  (pipe_valid_out),
        .pipe_end_out    (pipe_end_out),
        .pipe_busy_in    (pipe_busy_in),
        .grant_out       (grant_out),
        .frame_beats_out (frame_beats_out),
        .frame_done_out  (frame_done_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Source items: bit 33 valid, bit 32 end, [31:0] data.
    logic [33:0] q [4][$];

    always begin
        bit cons [4];
        logic [33:0] head;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            cons[i] = q[i].size() > 0 && (q[i][0][33] ? !src_busy_out[i] : grant_out[i]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (cons[i]) void'(q[i].pop_front());
            head = q[i].size() > 0 ? q[i][0] : '0;
            src_valid_in[i]         = head[33];
            src_end_in[i]           = head[32];
            src_data_in[i*32 +: 32] = head[31:0];
        end
    end

    // Reference model: owner = granted source (-1 none), closing = report cycle pending.
    int m_own = -1;
    bit m_close = 0;
    int m_ptr = 0, m_cnt = 0, m_idle = 0, m_last = 0;

    always @(negedge clk) begin
        bit ex, bt, en, et;
        int o;
        logic [3:0] eb;
        ex = m_own >= 0 && !m_close;
        o  = ex ? m_own : 0;
        bt = ex && src_valid_in[o] && !pipe_busy_in;
        en = ex && src_end_in[o];
        et = ex && !bt && !en && m_idle == 15;
        for (int i = 0; i < 4; i++) eb[i] = (ex && i == o) ? pipe_busy_in : 1'b1;
        chk("grant", grant_out, m_own >= 0 ? (64'd1 << m_own) : 64'd0);
        chk("src_busy", src_busy_out, eb);
        chk("pipe_valid", pipe_valid_out, ex && src_valid_in[o]);
        chk("pipe_data", pipe_data_out, ex ? src_data_in[o*32 +: 32] : 32'd0);
        chk("pipe_end", pipe_end_out, en || et);
        chk("timeout", timeout_out, et);
        chk("frame_done", frame_done_out, m_close);
        chk("frame_beats", frame_beats_out, m_last);
        if (rst) begin
            m_own = -1; m_close = 0; m_ptr = 0; m_cnt = 0; m_idle = 0; m_last = 0;
        end else if (m_own < 0) begin
            for (int k = 3; k >= 0; k--)
                if (src_valid_in[(m_ptr + k) % 4]) m_own = (m_ptr + k) % 4;
            m_cnt = 0; m_idle = 0;
        end else if (m_close) begin
            m_ptr = (m_own + 1) % 4; m_own = -1; m_close = 0;
        end else begin
            if (bt && m_cnt < 65535) m_cnt++;
            m_idle = (bt || en) ? 0 : m_idle + 1;
            if (en || et) begin m_close = 1; m_last = m_cnt; end
        end
    end

    // Observation log for the hand-computed expectations.
    int cyc = 0, last_beat = 0, to_gap = 0, to_cnt = 0, done_cnt = 0, ve_cnt = 0;
    bit to_end = 0;
    logic [3:0] pg = 0;
    logic [3:0] glog [$];
    logic [31:0] dlog [$];

    always @(negedge clk) begin
        cyc++;
        if (pipe_valid_out && !pipe_busy_in) begin
            dlog.push_back(pipe_data_out);
            last_beat = cyc;
            if (pipe_end_out) ve_cnt++;
        end
        if (grant_out != 0 && grant_out != pg) glog.push_back(grant_out);
        pg = grant_out;
        if (timeout_out) begin to_cnt++; to_gap = cyc - last_beat; to_end = pipe_end_out; end
        if (frame_done_out) done_cnt++;
    end

    task automatic wait_done(input int budget, input string nm, input int beats);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = frame_done_out;
        end
        chk({nm, "_done_seen"}, ok, 1);
        chk({nm, "_beats"}, frame_beats_out, beats);
    endtask

    task automatic wait_beats(input int budget, input int cnt);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = dlog.size() >= cnt;
        end
        chk("beats_reached", ok, 1);
    endtask

    task automatic clear_logs();
        glog.delete();
        dlog.delete();
    endtask

    initial begin
        logic [31:0] exp_d [$];
        int saved;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_grant", grant_out, 0);
        chk("rst_busy", src_busy_out, 4'hf);
        chk("rst_beats", frame_beats_out, 0);
        chk("rst_done", frame_done_out, 0);
        chk("rst_timeout", timeout_out, 0);
        #1;
        // Single source, separate end strobe.
        for (int k = 0; k < 8; k++) q[1].push_back({2'b10, 32'h100 + k});
        q[1].push_back({2'b01, 32'h0});
        wait_done(40, "t1", 8);
        #1;
        chk("t1_grant", glog[0], 4'b0010);
        chk("t1_nbeats", dlog.size(), 8);
        chk("t1_last", dlog[7], 32'h107);
        clear_logs();
        // rr_ptr=2 makes src3 beat src0; src3 stalls mid-frame; both ends ride on a beat.
        for (int k = 0; k < 5; k++) q[3].push_back({1'b1, k == 4, 32'h300 + k});
        q[0].push_back({2'b11, 32'h0a0});
        wait_beats(50, 2);
        @(posedge clk);
        #1 pipe_busy_in = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_busy_all", src_busy_out, 4'hf);
        end
        @(posedge clk);
        #1 pipe_busy_in = 0;
        wait_done(40, "t3", 5);
        wait_done(40, "t4", 1);
        #1;
        chk("t3_grant0", glog[0], 4'b1000);
        chk("t3_grant1", glog[1], 4'b0001);
        exp_d = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h0a0};
        chk("t3_nbeats", dlog.size(), 6);
        foreach (exp_d[k]) chk("t3_data", dlog[k], exp_d[k]);
        chk("t4_valid_end", ve_cnt, 2);
        // Contention from reset.
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        #1;
        clear_logs();
        q[0].push_back({2'b10, 32'h010});
        q[0].push_back({2'b11, 32'h011});
        q[0].push_back({2'b10, 32'h012});
        q[0].push_back({2'b11, 32'h013});
        q[2].push_back({2'b10, 32'h200});
        q[2].push_back({2'b10, 32'h201});
        q[2].push_back({2'b11, 32'h202});
        wait_done(40, "t2a", 2);
        wait_done(40, "t2b", 3);
        wait_done(40, "t2c", 2);
        #1;
        chk("t2_grant0", glog[0], 4'b0001);
        chk("t2_grant1", glog[1], 4'b0100);
        chk("t2_grant2", glog[2], 4'b0001);
        exp_d = '{32'h010, 32'h011, 32'h200, 32'h201, 32'h202, 32'h012, 32'h013};
        chk("t2_nbeats", dlog.size(), 7);
        foreach (exp_d[k]) chk("t2_data", dlog[k], exp_d[k]);
        // Stall watchdog.
        for (int k = 0; k < 3; k++) q[0].push_back({2'b10, 32'h050 + k});
        wait_done(80, "t5", 3);
        #1;
        chk("t5_to_cnt", to_cnt, 1);
        chk("t5_to_gap", to_gap, 16);
        chk("t5_to_end", to_end, 1);
        // Reset mid-frame.
        clear_logs();
        q[0].push_back({2'b10, 32'h060});
        q[0].push_back({2'b11, 32'h061});
        for (int k = 0; k < 8; k++) q[2].push_back({2'b10, 32'h220 + k});
        q[2].push_back({2'b01, 32'h0});
        wait_beats(50, 4);
        saved = done_cnt;
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("t6_grant", grant_out, 0);
        chk("t6_busy", src_busy_out, 4'hf);
        chk("t6_done", frame_done_out, 0);
        wait_done(40, "t6a", 2);
        wait_done(40, "t6b", 3);
        #1;
        chk("t6_no_done", done_cnt, saved + 2);
        chk("t6_grant0", glog[0], 4'b0100);
        chk("t6_grant1", glog[1], 4'b0001);
        chk("t6_grant2", glog[2], 4'b0100);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
